// File: rtl/gray_pkg.sv
// Shared types, channel layout and arithmetic helpers for the grayscale stream path.
// Build with GRAY_LUMA_WEIGHTS_EN defined to get weighted luma instead of the plain average.
package gray_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int CH_W  = 8;
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  localparam int unsigned DIV3_MUL   = 683;
  localparam int unsigned DIV3_SHIFT = 11;

  localparam int unsigned LUMA_R     = 77;
  localparam int unsigned LUMA_G     = 150;
  localparam int unsigned LUMA_B     = 29;
  localparam int unsigned LUMA_SHIFT = 8;

`ifdef GRAY_LUMA_WEIGHTS_EN
  localparam int SUM_W = 17;
`else
  localparam int SUM_W = 10;
`endif

  typedef logic [SUM_W-1:0] sum_t;

  // Stage-1 arithmetic: channel sum, or the weighted sum when luma weights are enabled.
  function automatic sum_t stage1_sum(input logic [23:0] rgb);
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
    r = rgb[R_LSB +: CH_W];
    g = rgb[G_LSB +: CH_W];
    b = rgb[B_LSB +: CH_W];
`ifdef GRAY_LUMA_WEIGHTS_EN
    return sum_t'(LUMA_R) * sum_t'(r) + sum_t'(LUMA_G) * sum_t'(g) + sum_t'(LUMA_B) * sum_t'(b);
`else
    return sum_t'(r) + sum_t'(g) + sum_t'(b);
`endif
  endfunction

  // Stage-2 arithmetic: 683/2048 is an exact floor(x/3) for every sum up to 765.
  function automatic logic [CH_W-1:0] stage2_y(input sum_t s);
`ifdef GRAY_LUMA_WEIGHTS_EN
    return CH_W'(s >> LUMA_SHIFT);
`else
    return CH_W'((20'(s) * 20'(DIV3_MUL)) >> DIV3_SHIFT);
`endif
  endfunction

endpackage

// File: rtl/gray_stream_ctrl_if.sv
// FIFO-side signals of the grayscale controller: FWFT input FIFO read port and output FIFO write port.
interface gray_stream_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] in_dout;
  logic                  in_empty;
  logic                  in_rd_en;
  logic                  out_full;
  logic                  out_wr_en;
  logic [DATA_WIDTH-1:0] out_din;

  modport master (
    input  in_dout, in_empty, out_full,
    output in_rd_en, out_wr_en, out_din
  );

  modport slave (
    output in_dout, in_empty, out_full,
    input  in_rd_en, out_wr_en, out_din
  );
endinterface

// File: rtl/gray_pixel_pipe.sv
// Two-stage stallable RGB-to-gray pipeline; the whole pipe freezes while the output word is blocked.
module gray_pixel_pipe
  import gray_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [23:0] rgb,
  input  logic        out_full,
  output logic        advance,
  output logic        s1_valid,
  output logic        s2_valid,
  output logic        wr_en,
  output logic [7:0]  y
);

  sum_t s1_sum;

  assign advance = !(s2_valid && out_full);
  assign wr_en   = s2_valid && !out_full;

  // NOTE: sequential state is written with non-blocking assignments only; the data
  // registers are reset as well so the output word reads zero out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_sum   <= '0;
      y        <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_sum   <= stage1_sum(rgb);
      s2_valid <= s1_valid;
      y        <= stage2_y(s1_sum);
    end
  end

endmodule

// File: rtl/gray_stream_ctrl.sv
// Frame controller: pops frame_pixels RGB words, converts them, pushes gray words, pulses done.
// Optional weighted luma conversion is selected with GRAY_LUMA_WEIGHTS_EN.
module gray_stream_ctrl
  import gray_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 24
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] frame_pixels,
  output logic                   busy,
  output logic                   done,
  gray_stream_ctrl_if.master     bus
);

  state_t                 state;
  state_t                 state_nxt;
  logic [COUNT_WIDTH-1:0] n_pix;
  logic [COUNT_WIDTH-1:0] pop_cnt;
  logic                   advance;
  logic                   s1_valid;
  logic                   s2_valid;
  logic                   pop;
  logic                   last_pop;
  logic                   drain_done;
  logic [7:0]             y;

  assign pop      = (state == ST_RUN) && !bus.in_empty && advance && (pop_cnt < n_pix);
  assign last_pop = pop && (pop_cnt == n_pix - COUNT_WIDTH'(1));
  // The pipe is empty after this edge, so done lands the cycle after the final push.
  assign drain_done = !s1_valid && (!s2_valid || bus.out_wr_en);

  assign bus.in_rd_en = pop;
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);
  assign bus.out_din  = DATA_WIDTH'({y, y, y});

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = (frame_pixels == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (last_pop) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_done) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      n_pix   <= '0;
      pop_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) begin
        n_pix   <= frame_pixels;
        pop_cnt <= '0;
      end else if (pop) begin
        pop_cnt <= pop_cnt + COUNT_WIDTH'(1);
      end
    end
  end

  gray_pixel_pipe u_pipe (
    .clock    (clock),
    .reset    (reset),
    .in_valid (pop),
    .rgb      (bus.in_dout[23:0]),
    .out_full (bus.out_full),
    .advance  (advance),
    .s1_valid (s1_valid),
    .s2_valid (s2_valid),
    .wr_en    (bus.out_wr_en),
    .y        (y)
  );

  // Pad bits above the pixel are deliberately ignored.
  if (DATA_WIDTH > 24) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^bus.in_dout[DATA_WIDTH-1:24];
  end

endmodule

// File: tb/tb_gray_stream_ctrl.sv
// Self-checking bench for gray_stream_ctrl: FIFO models, scoreboard, directed and random frames.
module tb_gray_stream_ctrl;

  localparam int DW = 32;
  localparam int CW = 24;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] frame_pixels = '0;
  logic          busy;
  logic          done;

  gray_stream_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  gray_stream_ctrl #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .frame_pixels (frame_pixels),
    .busy         (busy),
    .done         (done),
    .bus          (bus)
  );

  always #5 clock = ~clock;

  // Input FIFO model (first-word-fall-through) and output FIFO full control.
  logic [DW-1:0] in_mem [1024];
  logic [9:0]    in_rp = '0;
  logic [9:0]    in_wp = '0;
  logic          starve = 1'b0;
  logic          full_force = 1'b0;

  assign bus.in_dout  = in_mem[in_rp];
  assign bus.in_empty = (in_rp == in_wp) || starve;
  assign bus.out_full = full_force;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pops = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic done_busy = 1'b0;
  int viol_empty = 0;
  int viol_full = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_q [$];
  int got_cyc [$];
  int pop_cyc [$];

  // Reference conversion straight from the pixel arithmetic rules.
  function automatic logic [DW-1:0] gray_ref(input logic [DW-1:0] w);
    int r, g, b, yv;
    r = int'(w[23:16]);
    g = int'(w[15:8]);
    b = int'(w[7:0]);
`ifdef GRAY_LUMA_WEIGHTS_EN
    yv = (77 * r + 150 * g + 29 * b) / 256;
`else
    yv = (r + g + b) / 3;
`endif
    return {8'h00, 8'(yv), 8'(yv), 8'(yv)};
  endfunction

  // Monitor: sample just before each rising edge, apply FIFO effects just after it.
  always begin : mon
    logic          rd;
    logic          wr;
    logic [DW-1:0] din;
    @(negedge clock);
    #4;
    cyc++;
    rd  = bus.in_rd_en;
    wr  = bus.out_wr_en;
    din = bus.out_din;
    if (rd && bus.in_empty) viol_empty++;
    if (wr && bus.out_full) viol_full++;
    if (done) begin
      done_cnt++;
      done_cyc  = cyc;
      done_busy = busy;
    end
    @(posedge clock);
    #1;
    if (rd) begin
      pops++;
      pop_cyc.push_back(cyc);
      in_rp++;
    end
    if (wr) begin
      got_q.push_back(din);
      got_cyc.push_back(cyc);
    end
  end

  task automatic clear_sb();
    in_rp = '0;
    in_wp = '0;
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
    pop_cyc.delete();
    pops = 0;
    viol_empty = 0;
    viol_full = 0;
  endtask

  task automatic load(input logic [DW-1:0] w);
    in_mem[in_wp] = w;
    in_wp++;
    exp_q.push_back(gray_ref(w));
  endtask

  task automatic start_frame(input logic [CW-1:0] n, output int sc);
    @(negedge clock);
    start = 1'b1;
    frame_pixels = n;
    #5;
    sc = cyc;
    @(negedge clock);
    start = 1'b0;
    frame_pixels = CW'($urandom);
  endtask

  task automatic wait_done(input int d0, input int budget, output bit to);
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(posedge clock);
      k++;
    end
    to = (done_cnt == d0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    #4;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (bus.in_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b want 0", bus.in_rd_en); end
    total++; if (bus.out_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %b want 0", bus.out_wr_en); end
    total++; if (bus.out_din !== '0) begin bad++; $display("FAIL reset_din: got %h want 0", bus.out_din); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int d0, sc;
    bit to;
    clear_sb();
    load(32'h00FF_FFFF);
    load(32'h0000_0000);
    load(32'h0003_0303);
    load(32'h00FF_0000);
    d0 = done_cnt;
    start_frame(4, sc);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_done(d0, 100, to);
    total++; if (to) begin bad++; $display("FAIL basic_timeout: got no done want done"); end
    total++; if (pops != 4) begin bad++; $display("FAIL basic_pops: got %0d want 4", pops); end
    total++; if (got_q.size() != 4) begin bad++; $display("FAIL basic_count: got %0d want 4", got_q.size()); end
`ifndef GRAY_LUMA_WEIGHTS_EN
    total++; if (exp_q[3] !== 32'h0055_5555) begin bad++; $display("FAIL basic_model: got %h want 00555555", exp_q[3]); end
`endif
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      total++; if (got_cyc[i] != pop_cyc[0] + 2 + i) begin
        bad++; $display("FAIL basic_push_cycle[%0d]: got %0d want %0d", i, got_cyc[i], pop_cyc[0] + 2 + i);
      end
    end
    if (got_q.size() == 4) begin
      total++; if (done_cyc != got_cyc[3] + 1) begin bad++; $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc, got_cyc[3] + 1); end
    end
    total++; if (done_busy !== 1'b1) begin bad++; $display("FAIL basic_busy_at_done: got %b want 1", done_busy); end
    @(negedge clock);
    #4;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_divide();
    int d0, sc, r, g, b;
    bit to;
    clear_sb();
    for (int s = 0; s <= 765; s++) begin
      r = s / 3;
      g = (s - r) / 2;
      b = s - r - g;
      load({8'($urandom), 8'(r), 8'(g), 8'(b)});
    end
    d0 = done_cnt;
    start_frame(766, sc);
    wait_done(d0, 2000, to);
    total++; if (to) begin bad++; $display("FAIL divide_timeout: got no done want done"); end
    total++; if (got_q.size() != 766) begin bad++; $display("FAIL divide_count: got %0d want 766", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL divide_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
`ifdef GRAY_LUMA_WEIGHTS_EN
    clear_sb();
    load(32'h00FF_0000);
    load(32'h0000_FF00);
    d0 = done_cnt;
    start_frame(2, sc);
    wait_done(d0, 100, to);
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL luma_count: got %0d want 2", got_q.size()); end
    if (got_q.size() == 2) begin
      total++; if (got_q[0] !== 32'h004C_4C4C) begin bad++; $display("FAIL luma_red: got %h want 004c4c4c", got_q[0]); end
      total++; if (got_q[1] !== 32'h0095_9595) begin bad++; $display("FAIL luma_green: got %h want 00959595", got_q[1]); end
    end
`endif
  endtask

  task automatic test_backpressure();
    int d0, sc, k;
    bit to;
    clear_sb();
    for (int i = 0; i < 8; i++) load(DW'($urandom));
    d0 = done_cnt;
    start_frame(8, sc);
    k = 0;
    while (got_q.size() == 0 && k < 50) begin
      @(negedge clock);
      k++;
    end
    total++; if (got_q.size() == 0) begin bad++; $display("FAIL bp_first_push: got 0 pushes want 1"); end
    full_force = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #4;
      total++; if (bus.in_rd_en !== 1'b0) begin bad++; $display("FAIL bp_rd_en[%0d]: got %b want 0", i, bus.in_rd_en); end
      total++; if (bus.out_wr_en !== 1'b0) begin bad++; $display("FAIL bp_wr_en[%0d]: got %b want 0", i, bus.out_wr_en); end
      @(negedge clock);
    end
    full_force = 1'b0;
    wait_done(d0, 100, to);
    total++; if (to) begin bad++; $display("FAIL bp_timeout: got no done want done"); end
    total++; if (got_q.size() != 8) begin bad++; $display("FAIL bp_count: got %0d want 8", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_starvation();
    int d0, sc, k;
    clear_sb();
    for (int i = 0; i < 3; i++) load(DW'($urandom));
    d0 = done_cnt;
    start_frame(3, sc);
    k = 0;
    while (done_cnt == d0 && k < 200) begin
      @(negedge clock);
      starve = ~starve;
      k++;
    end
    starve = 1'b0;
    total++; if (done_cnt == d0) begin bad++; $display("FAIL starve_timeout: got no done want done"); end
    total++; if (pops != 3) begin bad++; $display("FAIL starve_pops: got %0d want 3", pops); end
    total++; if (got_q.size() != 3) begin bad++; $display("FAIL starve_pushes: got %0d want 3", got_q.size()); end
    total++; if (viol_empty != 0) begin bad++; $display("FAIL starve_rd_on_empty: got %0d want 0", viol_empty); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL starve_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_edge_starts();
    int d0, sc;
    bit to;
    clear_sb();
    d0 = done_cnt;
    start_frame(0, sc);
    wait_done(d0, 20, to);
    total++; if (to) begin bad++; $display("FAIL zero_timeout: got no done want done"); end
    total++; if (done_cyc != sc + 1) begin bad++; $display("FAIL zero_done_cycle: got %0d want %0d", done_cyc, sc + 1); end
    total++; if (pops != 0) begin bad++; $display("FAIL zero_pops: got %0d want 0", pops); end
    clear_sb();
    for (int i = 0; i < 8; i++) load(DW'($urandom));
    d0 = done_cnt;
    start_frame(5, sc);
    @(negedge clock);
    start = 1'b1;
    frame_pixels = 2;
    @(negedge clock);
    start = 1'b0;
    wait_done(d0, 100, to);
    repeat (10) @(negedge clock);
    total++; if (done_cnt != d0 + 1) begin bad++; $display("FAIL busy_start_dones: got %0d want %0d", done_cnt - d0, 1); end
    total++; if (pops != 5) begin bad++; $display("FAIL busy_start_pops: got %0d want 5", pops); end
    total++; if (got_q.size() != 5) begin bad++; $display("FAIL busy_start_pushes: got %0d want 5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL busy_start_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int d0, sc, k;
    bit to;
    clear_sb();
    for (int i = 0; i < 10; i++) load(DW'($urandom));
    d0 = done_cnt;
    start_frame(10, sc);
    k = 0;
    while (pops < 4 && k < 50) begin
      @(posedge clock);
      #2;
      k++;
    end
    reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rmid_done: got %b want 0", done); end
    total++; if (bus.in_rd_en !== 1'b0) begin bad++; $display("FAIL rmid_rd_en: got %b want 0", bus.in_rd_en); end
    total++; if (bus.out_wr_en !== 1'b0) begin bad++; $display("FAIL rmid_wr_en: got %b want 0", bus.out_wr_en); end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    total++; if (done_cnt != d0) begin bad++; $display("FAIL rmid_no_done: got %0d want 0", done_cnt - d0); end
    clear_sb();
    load(DW'($urandom));
    load(DW'($urandom));
    start_frame(2, sc);
    wait_done(d0, 50, to);
    total++; if (to) begin bad++; $display("FAIL rmid_restart_timeout: got no done want done"); end
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL rmid_restart_count: got %0d want 2", got_q.size()); end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rmid_restart_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int d0, sc, n, k;
    for (int f = 0; f < 3; f++) begin
      clear_sb();
      n = 20 + $urandom_range(0, 20);
      for (int i = 0; i < n; i++) load(DW'($urandom));
      d0 = done_cnt;
      start_frame(CW'(n), sc);
      k = 0;
      while (done_cnt == d0 && k < 1000) begin
        @(negedge clock);
        full_force = ($urandom_range(0, 3) == 0);
        starve     = ($urandom_range(0, 3) == 0);
        k++;
      end
      full_force = 1'b0;
      starve = 1'b0;
      total++; if (done_cnt == d0) begin bad++; $display("FAIL rnd%0d_timeout: got no done want done", f); end
      total++; if (pops != n) begin bad++; $display("FAIL rnd%0d_pops: got %0d want %0d", f, pops, n); end
      total++; if (got_q.size() != n) begin bad++; $display("FAIL rnd%0d_count: got %0d want %0d", f, got_q.size(), n); end
      total++; if (viol_empty + viol_full != 0) begin
        bad++; $display("FAIL rnd%0d_handshake: got %0d violations want 0", f, viol_empty + viol_full);
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd%0d_data[%0d]: got %h want %h", f, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_divide();
    test_backpressure();
    test_starvation();
    test_edge_starts();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
